// File: rtl/bpu_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Struct field widths follow the default XLEN/TAG_W of branch_predict_unit.
package bpu_pkg;

  localparam int BPU_XLEN  = 32;
  localparam int BPU_TAG_W = 10;

  typedef enum logic [1:0] {
    BR   = 2'b00,
    JMP  = 2'b01,
    CALL = 2'b10,
    RET  = 2'b11
  } btb_type_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [BPU_XLEN-1:0]  target;
    btb_type_t            btype;
    ctr_t                 ctr;
  } btb_entry_t;

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty is ignored.
module bpu_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  stk_q [DEPTH];
  logic [XLEN-1:0]  stk_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stk_d = stk_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      stk_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stored addresses are only meaningful while cnt_q says so; no reset needed.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign top   = stk_q[ptr_q - PTR_W'(1)];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, EX-side training.
// Optional return-address stack enabled by defining BPU_RAS_EN.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int   XLEN      = BPU_XLEN,
  parameter int   ENTRIES   = 64,
  parameter int   TAG_W     = BPU_TAG_W,
  parameter ctr_t CTR_INIT  = WT,
  parameter int   RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lk_valid,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_type,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  btb_entry_t       lk_ent, upd_ent;
  logic             upd_hit;
  btb_type_t        upd_btype;
  logic [XLEN-1:0]  lk_seq;
  logic [XLEN-1:0]  jmp_tgt;
  logic             unused_upd;

  assign lk_idx    = lk_pc[IDX_W+1:2];
  assign lk_tag    = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_btype = btb_type_t'(upd_type);
  assign unused_upd = ^{upd_pc[1:0], upd_pc[XLEN-1:IDX_W+TAG_W+2]};

  assign lk_ent  = btb_q[lk_idx];
  assign upd_ent = btb_q[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);
  assign lk_seq  = lk_pc + XLEN'(4);

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign pred_hit   = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign pred_taken = pred_hit && ((lk_ent.btype != BR) || lk_ent.ctr[1]);

`ifdef BPU_RAS_EN
  logic            ras_push, ras_pop, ras_empty;
  logic [XLEN-1:0] ras_top;

  assign ras_push = lk_valid && pred_hit && (lk_ent.btype == CALL);
  assign ras_pop  = lk_valid && pred_hit && (lk_ent.btype == RET);

  bpu_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (lk_seq),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign jmp_tgt = ((lk_ent.btype == RET) && !ras_empty) ? ras_top : lk_ent.target;
`else
  assign jmp_tgt = lk_ent.target;
`endif

  assign pred_target = pred_taken ? jmp_tgt : lk_seq;

  // Training: counters move only for branches; a miss allocates only when taken.
  always_comb begin
    btb_d = btb_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_btype == BR) btb_d[upd_idx].ctr = ctr_step(upd_ent.ctr, upd_taken);
        if (upd_taken) begin
          btb_d[upd_idx].target = upd_target;
          btb_d[upd_idx].btype  = upd_btype;
        end
      end else if (upd_taken) begin
        btb_d[upd_idx] = '{valid:  1'b1,
                           tag:    upd_tag,
                           target: upd_target,
                           btype:  upd_btype,
                           ctr:    (upd_btype == BR) ? CTR_INIT : ST};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else begin
      btb_q <= btb_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed cases then random traffic
// against a table-level reference model; RAS cases when BPU_RAS_EN is defined.
module tb_branch_predict_unit;

  localparam int ENTRIES   = 64;
  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .XLEN      (32),
    .ENTRIES   (ENTRIES),
    .TAG_W     (10),
    .CTR_INIT  (2'b10),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lk_valid    (lk_valid),
    .lk_pc       (lk_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_type    (upd_type),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  typedef struct {
    bit          hit;
    bit          taken;
    logic [31:0] target;
    logic [31:0] pc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per BTB slot, counter as a plain integer 0..3.
  bit          m_v   [ENTRIES];
  int          m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_typ [ENTRIES];
  int          m_ctr [ENTRIES];
`ifdef BPU_RAS_EN
  logic [31:0] m_ras[$];
`endif

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % 1024);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
`ifdef BPU_RAS_EN
    m_ras.delete();
`endif
  endtask

  task automatic model_lookup(input logic [31:0] pc, output exp_t e);
    int s;
    s        = slot_of(pc);
    e.pc     = pc;
    e.hit    = m_v[s] && (m_tag[s] == tag_of(pc));
    e.taken  = e.hit && ((m_typ[s] != 0) || (m_ctr[s] >= 2));
    e.target = pc + 32'd4;
    if (e.taken) e.target = m_tgt[s];
`ifdef BPU_RAS_EN
    if (e.hit && m_typ[s] == 3 && m_ras.size() > 0) e.target = m_ras[$];
    if (e.hit && m_typ[s] == 2) begin
      m_ras.push_back(pc + 32'd4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (e.hit && m_typ[s] == 3 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
`endif
  endtask

  task automatic model_update(input logic [31:0] pc, input int ty, input bit tk,
                              input logic [31:0] tg);
    int s;
    s = slot_of(pc);
    if (m_v[s] && m_tag[s] == tag_of(pc)) begin
      if (ty == 0) m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                 : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
      if (tk) begin
        m_tgt[s] = tg;
        m_typ[s] = ty;
      end
    end else if (tk) begin
      m_v[s]   = 1'b1;
      m_tag[s] = tag_of(pc);
      m_tgt[s] = tg;
      m_typ[s] = ty;
      m_ctr[s] = (ty == 0) ? 2 : 3;
    end
  endtask

  // One clock of stimulus: expectation is taken from the pre-update model.
  task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input int ty, input bit tk,
                      input logic [31:0] tg);
    exp_t e;
    lk_valid   = lv;
    lk_pc      = lpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_type   = ty[1:0];
    upd_taken  = tk;
    upd_target = tg;
    if (lv) begin
      model_lookup(lpc, e);
      expq.push_back(e);
    end
    if (uv) model_update(upc, ty, tk, tg);
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pc, input int ty, input bit tk, input logic [31:0] tg);
    step(1'b0, 32'h0, 1'b1, pc, ty, tk, tg);
  endtask

  // Reset with an update in flight: the update must be lost and lookups miss at once.
  task automatic pulse_rst(input logic [31:0] pc);
    exp_t e;
    rst        = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_type   = 2'b00;
    upd_taken  = 1'b1;
    upd_target = 32'h0000_1234;
    lk_valid   = 1'b1;
    lk_pc      = pc;
    model_clear();
    e.pc = pc; e.hit = 1'b0; e.taken = 1'b0; e.target = pc + 32'd4;
    expq.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (lk_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_lookup pc=%h: no expectation queued", lk_pc);
      end else begin
        mon_e = expq.pop_front();
        checks++;
        if (pred_hit !== mon_e.hit) begin
          errors++;
          $display("FAIL pred_hit pc=%h: got %b want %b", mon_e.pc, pred_hit, mon_e.hit);
        end
        checks++;
        if (pred_taken !== mon_e.taken) begin
          errors++;
          $display("FAIL pred_taken pc=%h: got %b want %b", mon_e.pc, pred_taken, mon_e.taken);
        end
        checks++;
        if (pred_target !== mon_e.target) begin
          errors++;
          $display("FAIL pred_target pc=%h: got %h want %h", mon_e.pc, pred_target, mon_e.target);
        end
      end
    end
  end

  logic [31:0] pool_pc [12];
  int          pool_ty [12];

  initial begin
    rst = 1'b1;
    lk_valid = 1'b0; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_type = '0; upd_taken = 1'b0; upd_target = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    look(32'h100);
    upd(32'h200, 0, 1'b1, 32'h180);
    look(32'h200);
    upd(32'h200, 0, 1'b0, 32'h0);
    upd(32'h200, 0, 1'b0, 32'h0);
    look(32'h200);
    for (int i = 0; i < 4; i++) upd(32'h200, 0, 1'b1, 32'h180);
    look(32'h200);
    upd(32'h200, 0, 1'b0, 32'h0);
    look(32'h200);
    upd(32'h208, 0, 1'b0, 32'h280);
    look(32'h208);
    upd(32'h200 + 4 * ENTRIES, 0, 1'b1, 32'h700);
    look(32'h200);
    look(32'h200 + 4 * ENTRIES);
    step(1'b1, 32'h300, 1'b1, 32'h300, 0, 1'b0, 32'h0);
    look(32'h300);
    look(32'hFFFF_FFFC);
    upd(32'h40, 1, 1'b1, 32'h800);
    look(32'h40);

`ifdef BPU_RAS_EN
    upd(32'h300, 2, 1'b1, 32'h500);
    upd(32'h404, 3, 1'b1, 32'h990);
    look(32'h300);
    look(32'h404);
    look(32'h404);
    for (int k = 0; k <= RAS_DEPTH; k++) upd(32'h1000 + 16 * k, 2, 1'b1, 32'h2000);
    for (int k = 0; k <= RAS_DEPTH; k++) look(32'h1000 + 16 * k);
    for (int k = 0; k <= RAS_DEPTH + 1; k++) look(32'h404);
    look(32'h300);
`endif

    pulse_rst(32'h40);
    look(32'h40);
    look(32'h200);
    look(32'h404);

    for (int i = 0; i < 12; i++) begin
      pool_pc[i] = {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
      pool_ty[i] = i % 4;
    end
    for (int n = 0; n < 600; n++) begin
      int a, b, ty;
      logic [31:0] lpc;
      if (n == 300) pulse_rst(pool_pc[0]);
      a   = $urandom_range(0, 11);
      b   = $urandom_range(0, 11);
      ty  = pool_ty[b];
      lpc = ($urandom_range(0, 15) == 0) ? {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} : pool_pc[a];
      step($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 1) == 1, pool_pc[b], ty,
           (ty == 0) ? ($urandom_range(0, 2) != 0) : 1'b1,
           {14'h0, 16'($urandom), 2'b00});
    end

    lk_valid = 1'b0;
    upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
